// File: rtl/fifo_pkg.sv
// Defaults shared by the FIFO and its reader, plus the reader state encoding.
package fifo_pkg;
    localparam int FIFO_BITS  = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int FIFO_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rd_state_e;
endpackage

// File: rtl/fifo_flops.sv
// Flop-based first-word-fall-through FIFO; DEPTH must be a power of two.
module fifo_flops
    import fifo_pkg::*;
#(
    parameter int BITS  = FIFO_BITS,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] Din,
    input  logic            pop,
    output logic [BITS-1:0] Dout,
    output logic            pndng,
    output logic            full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [BITS-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             wr, rd;

    assign full  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign pndng = (cnt_q != '0);
    assign wr    = push & ~full;
    assign rd    = pop & pndng;
    assign Dout  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= Din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer; entry 0 always drives the stream.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int BITS = FIFO_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [BITS-1:0] din,
    input  logic            out_ready,
    output logic [BITS-1:0] out_data,
    output logic            out_valid,
    output logic [1:0]      occ
);
    logic [BITS-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [1:0]      occ_q, occ_d;
    logic            take;

    assign take      = (occ_q != 2'd0) & out_ready;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = d0_q;
    assign occ       = occ_q;

    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        occ_d = occ_q;
        if (clear) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        d0_d  = din;
                        occ_d = 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, take})
                        2'b11: d0_d = din;
                        2'b10: begin
                            d1_d  = din;
                            occ_d = 2'd2;
                        end
                        2'b01: occ_d = 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    // Full: a new word can only land if the head leaves this cycle.
                    if (take) begin
                        d0_d = d1_q;
                        if (push) d1_d  = din;
                        else      occ_d = 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d0_q  <= '0;
            d1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            occ_q <= occ_d;
        end
    end
endmodule

// File: rtl/fifo_reader.sv
// Pops a FWFT FIFO into a valid/ready stream, with flush and a popped-word counter.
//   state | meaning
//   IDLE  | no pops; buffered words still drain downstream
//   RUN   | pop while FIFO has data and buffer has room; count pops
//   FLUSH | pop and discard until FIFO empty; buffer cleared on entry
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int BITS  = FIFO_BITS,
    parameter int CNT_W = FIFO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             pndng,
    input  logic [BITS-1:0]  Dout,
    output logic             pop,
    output logic [BITS-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_cnt,
    output logic             flush_done,
    output logic             busy
);
    rd_state_e        state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q;
    logic             flush_done_q;
    logic             skid_clear, skid_push;
    logic [1:0]       occ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (flush) state_d = ST_FLUSH; else if (en)  state_d = ST_RUN;
            ST_RUN:   if (flush) state_d = ST_FLUSH; else if (!en) state_d = ST_IDLE;
            ST_FLUSH: if (!pndng && !flush) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        busy       = 1'b0;
        skid_clear = (state_d == ST_FLUSH) && (state_q != ST_FLUSH);
        skid_push  = 1'b0;
        case (state_q)
            ST_RUN: begin
                pop       = pndng & (occ < 2'd2);
                skid_push = pop;
            end
            ST_FLUSH: begin
                pop  = pndng;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q   <= '0;
            flush_done_q <= 1'b0;
        end else begin
            if ((state_q == ST_RUN) && pop && (word_cnt_q != '1))
                word_cnt_q <= word_cnt_q + 1'b1;
            flush_done_q <= (state_q == ST_FLUSH) && (state_d == ST_IDLE);
        end
    end

    assign word_cnt   = word_cnt_q;
    assign flush_done = flush_done_q;

    fifo_reader_skid #(.BITS(BITS)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clear     (skid_clear),
        .push      (skid_push),
        .din       (Dout),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .occ       (occ)
    );
endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench: fifo_flops (16x16) feeding fifo_reader, hand-computed expectations.
module tb_fifo_reader;
    localparam int BITS  = 16;
    localparam int CNT_W = 16;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst, f_rst, en, flush, out_ready, f_push;
    logic [BITS-1:0]  f_din, dout, out_data;
    logic             pndng, pop, full, out_valid, flush_done, busy;
    logic [CNT_W-1:0] word_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_flops #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(f_rst), .push(f_push), .Din(f_din), .pop(pop),
        .Dout(dout), .pndng(pndng), .full(full)
    );

    fifo_reader #(.BITS(BITS), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .pndng(pndng), .Dout(dout),
        .pop(pop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .word_cnt(word_cnt), .flush_done(flush_done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_words(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            f_push = 1'b1;
            f_din  = BITS'(base + i);
            cyc();
        end
        f_push = 1'b0;
    endtask

    task automatic collect(input int n, input int base, input int budget, input string tag,
                           output int first_c, output int last_c);
        int got;
        got     = 0;
        first_c = -1;
        last_c  = -1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (out_valid && out_ready) begin
                chk($sformatf("%s_w%0d", tag, got), 32'(out_data), 32'(base + got));
                if (first_c < 0) first_c = c;
                last_c = c;
                got++;
            end
            cyc();
        end
        chk({tag, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int pops, valids, fds, first_c, last_c, recv, sent;
        rst = 1'b0; f_rst = 1'b0; en = 1'b0; flush = 1'b0;
        out_ready = 1'b0; f_push = 1'b0; f_din = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pop", 32'(pop), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_cnt", 32'(word_cnt), 0);
        chk("rst_fdone", 32'(flush_done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1; f_rst = 1'b1;
        cyc();

        // Empty FIFO with en held high.
        en = 1'b1; out_ready = 1'b1;
        pops = 0; valids = 0;
        for (int c = 0; c < 20; c++) begin
            if (pop) pops++;
            if (out_valid) valids++;
            cyc();
        end
        chk("empty_pops", 32'(pops), 0);
        chk("empty_valid", 32'(valids), 0);
        chk("empty_cnt", 32'(word_cnt), 0);
        en = 1'b0; out_ready = 1'b0;
        cyc();

        // Streaming 0..15 with ready held high.
        push_words(16, 0);
        en = 1'b1; out_ready = 1'b1;
        collect(16, 0, 40, "stream", first_c, last_c);
        chk("stream_consec", 32'(last_c - first_c), 15);
        chk("stream_cnt", 32'(word_cnt), 16);
        chk("stream_empty", 32'(out_valid), 0);

        // Backpressure: full FIFO, ready low.
        en = 1'b0; out_ready = 1'b0;
        cyc();
        push_words(16, 0);
        en = 1'b1;
        pops = 0;
        for (int c = 0; c < 10; c++) begin
            if (pop) pops++;
            cyc();
        end
        chk("bp_pops", 32'(pops), 2);
        chk("bp_pop_now", 32'(pop), 0);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data", 32'(out_data), 0);
        out_ready = 1'b1;
        collect(16, 0, 40, "bp", first_c, last_c);
        chk("bp_cnt", 32'(word_cnt), 32);

        // Flush with 8 queued words while idle.
        en = 1'b0;
        cyc();
        push_words(8, 50);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_busy", 32'(busy), 1);
        pops = 0; valids = 0; fds = 0;
        for (int c = 0; c < 30; c++) begin
            if (pop) pops++;
            if (out_valid) valids++;
            if (flush_done) fds++;
            cyc();
        end
        chk("fl_pops", 32'(pops), 8);
        chk("fl_valid", 32'(valids), 0);
        chk("fl_done_pulses", 32'(fds), 1);
        chk("fl_pndng", 32'(pndng), 0);
        chk("fl_cnt", 32'(word_cnt), 32);
        chk("fl_busy_end", 32'(busy), 0);

        // Reset with 2 words buffered and 5 left in the FIFO.
        out_ready = 1'b0;
        push_words(7, 100);
        en = 1'b1;
        repeat (6) cyc();
        chk("rs_pre_valid", 32'(out_valid), 1);
        chk("rs_pre_data", 32'(out_data), 100);
        #1 rst = 1'b0;
        #1;
        chk("rs_valid", 32'(out_valid), 0);
        chk("rs_cnt", 32'(word_cnt), 0);
        chk("rs_pop", 32'(pop), 0);
        chk("rs_data", 32'(out_data), 0);
        cyc();
        rst = 1'b1;
        chk("rs_release_pop", 32'(pop), 0);
        out_ready = 1'b1;
        collect(5, 102, 30, "rs", first_c, last_c);
        chk("rs_pndng", 32'(pndng), 0);

        // Slow writer, toggling ready, 40 words.
        recv = 0; sent = 0;
        for (int k = 0; k < 400 && recv < 40; k++) begin
            out_ready = ((k % 5) < 3);
            if (out_valid && out_ready) begin
                chk($sformatf("mix_w%0d", recv), 32'(out_data), 32'(300 + recv));
                recv++;
            end
            f_push = ((k % 2) == 0) && (sent < 40);
            if (f_push) begin
                f_din = BITS'(300 + sent);
                sent++;
            end
            cyc();
        end
        f_push = 1'b0;
        chk("mix_count", 32'(recv), 40);
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("mix_no_dup", 32'(out_valid), 0);
        chk("mix_cnt", 32'(word_cnt), 45);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter BITS, default 16, data word width.
REQ-002 SHALL have parameter CNT_W, default 16, width of popped-word counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  enables normal forwarding from FIFO to stream.
REQ-006 SHALL have port flush  input  1  single-cycle request to discard FIFO and buffer contents.
REQ-007 SHALL have port pndng  input  1  FIFO not-empty flag from fifo_flops.
REQ-008 SHALL have port Dout  input  BITS  FIFO head word, valid whenever pndng=1 (first-word-fall-through).
REQ-009 SHALL have port pop  output  1  FIFO pop; head removed at rising edge where pop=1.
REQ-010 SHALL have port out_data  output  BITS  downstream data.
REQ-011 SHALL have port out_valid  output  1  downstream valid.
REQ-012 SHALL have port out_ready  input  1  downstream ready; transfer when out_valid & out_ready at rising edge.
REQ-013 SHALL have port word_cnt  output  CNT_W  words popped in RUN, saturating.
REQ-014 SHALL have port flush_done  output  1  one-cycle pulse at end of flush.
REQ-015 SHALL have port busy  output  1  high in FLUSH state.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH.
REQ-017 IDLE->RUN when en=1 and flush=0; RUN->IDLE when en=0 and flush=0.
REQ-018 IDLE or RUN -> FLUSH when flush=1 (flush has priority over en).
REQ-019 FLUSH->IDLE when pndng=0 at rising edge and no flush=1 that cycle; flush_done=1 for exactly the following cycle.
REQ-020 flush=1 while in FLUSH SHALL be ignored (no restart, no extra pulse).
REQ-021 In RUN, pop = pndng & (buffer occupancy < 2), combinational from registered occupancy and pndng.
REQ-022 In FLUSH, pop = pndng; popped words discarded; 2-entry buffer cleared on FLUSH entry edge.
REQ-023 In IDLE, pop = 0; buffered words still drain downstream.
REQ-024 pop SHALL never be 1 while pndng=0 (no underflow in any state).
REQ-025 Word popped at edge N SHALL be written to buffer at edge N and appear on out_data with out_valid=1 from cycle N+1 (latency 1).
REQ-026 Buffer SHALL be 2-entry, in-order; sustained throughput 1 word/cycle with out_ready held 1.
REQ-027 Simultaneous pop-capture and downstream transfer in one cycle SHALL leave occupancy unchanged.
REQ-028 out_valid=0 whenever occupancy=0; out_data unchanged while out_valid=1 and out_ready=0.
REQ-029 word_cnt SHALL increment by 1 per RUN-state pop, hold at 2^CNT_W-1, not count FLUSH pops.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, occupancy 0, pop=0, out_valid=0, out_data=0, word_cnt=0, flush_done=0, busy=0.
REQ-031 Reset mid-flush or mid-transfer SHALL discard buffer contents; no flush_done pulse generated.
REQ-032 Deassertion SHALL take effect at next rising edge; no pop in the first cycle after release.

Structure
REQ-033 Shared package fifo_pkg SHALL hold BITS/DEPTH defaults and the reader state enum.
REQ-034 The 2-entry buffer SHALL be sub-module fifo_reader_skid; FSM, pop logic and counter in fifo_reader.
REQ-035 Bench SHALL pair fifo_reader with fifo_flops (DEPTH 16, BITS 16).

Verification
REQ-036 Push 0..15 into FIFO, en=1, out_ready=1 -> out_data 0..15 in order on 16 consecutive cycles, word_cnt=16.
REQ-037 FIFO full (16 words), out_ready=0 -> exactly 2 pops, pop=0 afterwards, out_data=0 held; out_ready=1 -> remaining 14 delivered in order.
REQ-038 Empty FIFO, en=1 for 20 cycles -> pop never 1, out_valid=0, word_cnt=0.
REQ-039 8 words queued, flush pulse -> busy=1, 8 pops, no out_valid, flush_done=1 one cycle, FIFO pndng=0, word_cnt unchanged.
REQ-040 rst=0 asserted with 2 words buffered, 5 in FIFO -> out_valid=0, word_cnt=0 same cycle; after release with en=1, remaining 5 delivered.
REQ-041 Writer pushing one word every other cycle, out_ready toggling -> no loss, no duplicate, order preserved over 40 words.
